// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory handshake bundle for multicycle_sequencer.
// master: sequencer side; slave: memory side.
interface multicycle_sequencer_if;
  logic       fetch_req;
  logic       ir_write;
  logic       instr_valid;
  logic [1:0] opcode;
  logic       mem_ready;
  logic       signal_memread;
  logic       signal_memwrite;

  modport master (
    output fetch_req, ir_write, signal_memread, signal_memwrite,
    input  instr_valid, opcode, mem_ready
  );

  modport slave (
    input  fetch_req, ir_write, signal_memread, signal_memwrite,
    output instr_valid, opcode, mem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 2-bit-opcode datapath.
// Optional memory-timeout watchdog enabled by defining MEM_TIMEOUT_EN.
module multicycle_sequencer #(
  parameter int unsigned COUNT_W = 16
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned MEM_TIMEOUT = 255
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   alu_zero,
  multicycle_sequencer_if.master mem,
  output logic                   pc_inc,
  output logic                   pc_branch,
  output logic                   signal_regdst,
  output logic                   signal_alusrc,
  output logic                   signal_aluop,
  output logic                   signal_memtoreg,
  output logic                   signal_regwrite,
  output logic                   busy,
  output logic                   instr_done,
  output logic [COUNT_W-1:0]     instr_count,
  output logic                   err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [1:0] {OP_R, OP_LOAD, OP_STORE, OP_BRANCH} opcode_t;

  state_t  state, state_next;
  opcode_t opc_q;
  logic    timeout;
  state_t  boundary;

  assign boundary = run ? FETCH : IDLE;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       waiting;

  assign waiting = ((state == FETCH) && !mem.instr_valid) ||
                   ((state == MEM)   && !mem.mem_ready);
  assign timeout = waiting && (wait_cnt == 8'(MEM_TIMEOUT - 1));

  // Wait counter: cleared on any state change, so it restarts on entry to FETCH/MEM
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (waiting)             wait_cnt <= wait_cnt + 8'd1;
  end

  // Sticky timeout error
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Opcode latch and retired-instruction counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opc_q       <= OP_R;
      instr_count <= '0;
    end else begin
      if (mem.ir_write) opc_q <= opcode_t'(mem.opcode);
      if (instr_done)   instr_count <= instr_count + COUNT_W'(1);
    end
  end

  // Next-state logic; run is only consulted in IDLE and at instruction boundaries
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (run && !err) state_next = FETCH;
      FETCH:  if (mem.instr_valid) state_next = DECODE;
              else if (timeout)    state_next = IDLE;
      DECODE: state_next = EXEC;
      EXEC: begin
        case (opc_q)
          OP_R:      state_next = WB;
          OP_LOAD:   state_next = MEM;
          OP_STORE:  state_next = MEM;
          OP_BRANCH: state_next = boundary;
          default:   state_next = IDLE;
        endcase
      end
      MEM:    if (mem.mem_ready) state_next = (opc_q == OP_LOAD) ? WB : boundary;
              else if (timeout)  state_next = IDLE;
      WB:     state_next = boundary;
      default: state_next = IDLE;
    endcase
  end

  // Moore control decode from state and latched opcode (ir_write/pc_inc/pc_branch also see inputs)
  always_comb begin
    mem.fetch_req       = 1'b0;
    mem.ir_write        = 1'b0;
    mem.signal_memread  = 1'b0;
    mem.signal_memwrite = 1'b0;
    pc_inc              = 1'b0;
    pc_branch           = 1'b0;
    signal_regdst       = 1'b0;
    signal_alusrc       = 1'b0;
    signal_aluop        = 1'b0;
    signal_memtoreg     = 1'b0;
    signal_regwrite     = 1'b0;
    instr_done          = 1'b0;
    busy                = (state != IDLE);
    case (state)
      FETCH: begin
        mem.fetch_req = 1'b1;
        mem.ir_write  = mem.instr_valid;
        pc_inc        = mem.instr_valid;
      end
      EXEC: begin
        case (opc_q)
          OP_R: begin
            signal_regdst = 1'b1;
            signal_aluop  = 1'b1;
          end
          OP_LOAD, OP_STORE: signal_alusrc = 1'b1;
          OP_BRANCH: begin
            pc_branch  = alu_zero;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        signal_alusrc       = 1'b1;
        mem.signal_memread  = (opc_q == OP_LOAD);
        mem.signal_memwrite = (opc_q == OP_STORE);
        instr_done          = (opc_q == OP_STORE) && mem.mem_ready;
      end
      WB: begin
        signal_regwrite = 1'b1;
        instr_done      = 1'b1;
        signal_regdst   = (opc_q == OP_R);
        signal_aluop    = (opc_q == OP_R);
        signal_memtoreg = (opc_q == OP_LOAD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
module tb_multicycle_sequencer;
  localparam int unsigned CW = 4;

  // Control vector layout:
  // {fetch_req, ir_write, pc_inc, pc_branch, regdst, alusrc, aluop,
  //  memtoreg, memread, memwrite, regwrite, busy, instr_done}
  localparam logic [12:0] C_IDLE    = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] C_FETCH_V = 13'b1_1_1_0_0_0_0_0_0_0_0_1_0;
  localparam logic [12:0] C_FETCH_W = 13'b1_0_0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [12:0] C_DEC     = 13'b0_0_0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [12:0] C_EX_R    = 13'b0_0_0_0_1_0_1_0_0_0_0_1_0;
  localparam logic [12:0] C_WB_R    = 13'b0_0_0_0_1_0_1_0_0_0_1_1_1;
  localparam logic [12:0] C_EX_LS   = 13'b0_0_0_0_0_1_0_0_0_0_0_1_0;
  localparam logic [12:0] C_MEM_LD  = 13'b0_0_0_0_0_1_0_0_1_0_0_1_0;
  localparam logic [12:0] C_WB_LD   = 13'b0_0_0_0_0_0_0_1_0_0_1_1_1;
  localparam logic [12:0] C_MEM_ST  = 13'b0_0_0_0_0_1_0_0_0_1_0_1_0;
  localparam logic [12:0] C_MEM_STD = 13'b0_0_0_0_0_1_0_0_0_1_0_1_1;
  localparam logic [12:0] C_EX_BZ   = 13'b0_0_0_1_0_0_0_0_0_0_0_1_1;
  localparam logic [12:0] C_EX_BN   = 13'b0_0_0_0_0_0_0_0_0_0_0_1_1;

  logic          clock = 1'b0;
  logic          reset;
  logic          run;
  logic          alu_zero;
  logic          pc_inc, pc_branch, signal_regdst, signal_alusrc, signal_aluop;
  logic          signal_memtoreg, signal_regwrite, busy, instr_done, err;
  logic [CW-1:0] instr_count;
  logic [12:0]   ctrl;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(
    .COUNT_W(CW)
`ifdef MEM_TIMEOUT_EN
    ,
    .MEM_TIMEOUT(4)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .alu_zero       (alu_zero),
    .mem            (bus.master),
    .pc_inc         (pc_inc),
    .pc_branch      (pc_branch),
    .signal_regdst  (signal_regdst),
    .signal_alusrc  (signal_alusrc),
    .signal_aluop   (signal_aluop),
    .signal_memtoreg(signal_memtoreg),
    .signal_regwrite(signal_regwrite),
    .busy           (busy),
    .instr_done     (instr_done),
    .instr_count    (instr_count),
    .err            (err)
  );

  assign ctrl = {bus.fetch_req, bus.ir_write, pc_inc, pc_branch, signal_regdst,
                 signal_alusrc, signal_aluop, signal_memtoreg, bus.signal_memread,
                 bus.signal_memwrite, signal_regwrite, busy, instr_done};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then check the control vector
  task automatic cyc(input string tag, input logic iv, input logic mr, input logic az,
                     input logic rn, input logic [1:0] op, input logic [12:0] exp);
    @(negedge clock);
    bus.instr_valid = iv;
    bus.mem_ready   = mr;
    alu_zero        = az;
    run             = rn;
    bus.opcode      = op;
    #1;
    check(tag, 32'(ctrl), 32'(exp));
  endtask

  // Counter value just after the next rising edge
  task automatic chk_count(input string tag, input logic [CW-1:0] exp);
    @(posedge clock);
    #1;
    check(tag, 32'(instr_count), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    alu_zero = 1'b0;
    bus.instr_valid = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode = 2'b00;
    repeat (2) @(negedge clock);
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // R-type, zero wait states
    cyc("idle_run",  0, 0, 0, 1, 2'b00, C_IDLE);
    cyc("r_fetch",   1, 0, 0, 1, 2'b00, C_FETCH_V);
    cyc("r_decode",  0, 0, 0, 1, 2'b00, C_DEC);
    cyc("r_exec",    0, 0, 0, 1, 2'b00, C_EX_R);
    cyc("r_wb",      0, 0, 0, 1, 2'b00, C_WB_R);
    chk_count("r_count", 4'd1);

    // Load with three memory wait cycles
    cyc("ld_fetch",  1, 0, 0, 1, 2'b01, C_FETCH_V);
    cyc("ld_decode", 0, 0, 0, 1, 2'b00, C_DEC);
    cyc("ld_exec",   0, 0, 0, 1, 2'b00, C_EX_LS);
    for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 0, 0, 0, 1, 2'b00, C_MEM_LD);
    cyc("ld_mem_rdy", 0, 1, 0, 1, 2'b00, C_MEM_LD);
    cyc("ld_wb",     0, 0, 0, 1, 2'b00, C_WB_LD);
    chk_count("ld_count", 4'd2);

    // Branch taken and not taken
    cyc("bz_fetch",  1, 0, 0, 1, 2'b11, C_FETCH_V);
    cyc("bz_decode", 0, 0, 0, 1, 2'b00, C_DEC);
    cyc("bz_exec",   0, 0, 1, 1, 2'b00, C_EX_BZ);
    chk_count("bz_count", 4'd3);
    cyc("bn_fetch",  1, 0, 0, 1, 2'b11, C_FETCH_V);
    cyc("bn_decode", 0, 0, 1, 1, 2'b00, C_DEC);
    cyc("bn_exec",   0, 0, 0, 1, 2'b00, C_EX_BN);
    chk_count("bn_count", 4'd4);

    // Store with a fetch wait; run dropped during MEM
    cyc("st_fetch_w", 0, 0, 0, 1, 2'b10, C_FETCH_W);
    cyc("st_fetch",   1, 0, 0, 1, 2'b10, C_FETCH_V);
    cyc("st_decode",  0, 0, 0, 1, 2'b00, C_DEC);
    cyc("st_exec",    0, 0, 0, 1, 2'b00, C_EX_LS);
    cyc("st_mem_w0",  0, 0, 0, 0, 2'b00, C_MEM_ST);
    cyc("st_mem_w1",  0, 0, 0, 0, 2'b00, C_MEM_ST);
    cyc("st_mem_rdy", 0, 1, 0, 0, 2'b00, C_MEM_STD);
    chk_count("st_count", 4'd5);
    cyc("st_idle",    0, 0, 0, 0, 2'b00, C_IDLE);
    cyc("st_idle2",   1, 1, 0, 0, 2'b00, C_IDLE);

    // Reset during a load's MEM state
    cyc("rl_idle",   0, 0, 0, 1, 2'b00, C_IDLE);
    cyc("rl_fetch",  1, 0, 0, 1, 2'b01, C_FETCH_V);
    cyc("rl_decode", 0, 0, 0, 1, 2'b00, C_DEC);
    cyc("rl_exec",   0, 0, 0, 1, 2'b00, C_EX_LS);
    cyc("rl_mem",    0, 0, 0, 1, 2'b00, C_MEM_LD);
    reset = 1'b1;
    #1;
    check("rl_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("rl_count", 32'(instr_count), 32'd0);
    check("rl_err", 32'(err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run = 1'b0;

    // Sixteen back-to-back branches wrap the 4-bit counter
    cyc("wr_idle", 0, 0, 0, 1, 2'b00, C_IDLE);
    for (int i = 0; i < 16; i++) begin
      cyc("wr_fetch",  1, 0, 0, 1, 2'b11, C_FETCH_V);
      cyc("wr_decode", 0, 0, 0, 1, 2'b00, C_DEC);
      cyc("wr_exec",   0, 0, 1, (i != 15), 2'b00, C_EX_BZ);
      chk_count("wr_count", CW'(i + 1));
    end
    cyc("wr_end_idle", 0, 0, 0, 0, 2'b00, C_IDLE);

    // Load whose memory never answers
    cyc("to_idle",   0, 0, 0, 1, 2'b00, C_IDLE);
    cyc("to_fetch",  1, 0, 0, 1, 2'b01, C_FETCH_V);
    cyc("to_decode", 0, 0, 0, 1, 2'b00, C_DEC);
    cyc("to_exec",   0, 0, 0, 1, 2'b00, C_EX_LS);
    for (int i = 0; i < 4; i++) cyc("to_mem_wait", 0, 0, 0, 1, 2'b00, C_MEM_LD);
`ifdef MEM_TIMEOUT_EN
    cyc("to_abort",  0, 0, 0, 1, 2'b00, C_IDLE);
    check("to_err", 32'(err), 32'd1);
    check("to_count", 32'(instr_count), 32'd0);
    cyc("to_stuck",  0, 0, 0, 1, 2'b00, C_IDLE);
    check("to_err_sticky", 32'(err), 32'd1);
`else
    cyc("to_mem_hold", 0, 0, 0, 1, 2'b00, C_MEM_LD);
    cyc("to_mem_hold", 0, 0, 0, 1, 2'b00, C_MEM_LD);
    check("to_err", 32'(err), 32'd0);
    cyc("to_mem_rdy", 0, 1, 0, 0, 2'b00, C_MEM_LD);
    cyc("to_wb",      0, 0, 0, 0, 2'b00, C_WB_LD);
    chk_count("to_count", 4'd1);
    cyc("to_end_idle", 0, 0, 0, 0, 2'b00, C_IDLE);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
